// File: rtl/demux_1x4_pipe.sv
// rtl/demux_1x4_pipe.sv - two-stage pipelined 1:4 demultiplexer with valid/ready lanes
// Optional stall counter port enabled by DEMUX_STALL_CNT_EN.
module demux_1x4_pipe #(
  parameter int DATA_WIDTH = 1,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in,
  input  logic [SEL_WIDTH-1:0]    sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*DATA_WIDTH-1:0] out,
  output logic [3:0]              out_valid,
`ifdef DEMUX_STALL_CNT_EN
  output logic [15:0]             stall_cnt,
`endif
  input  logic [3:0]              out_ready
);

  if (SEL_WIDTH != 2) begin : g_bad_sel
    $error("demux_1x4_pipe: SEL_WIDTH must be 2");
  end

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [SEL_WIDTH-1:0]  s1_sel;
  logic                  s1_adv;
  logic                  accept;
  logic [DATA_WIDTH-1:0] lane_data [4];

  // Stage 1 only waits on its own target lane; other lanes never block it.
  assign s1_adv   = s1_valid && (!out_valid[s1_sel] || out_ready[s1_sel]);
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sel   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in;
      s1_sel   <= sel;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // A load into a lane wins over its hand-off, so a busy lane streams without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) lane_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s1_adv && (s1_sel == SEL_WIDTH'(i))) begin
          lane_data[i] <= s1_data;
          out_valid[i] <= 1'b1;
        end else if (out_valid[i] && out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane_out
    assign out[g*DATA_WIDTH +: DATA_WIDTH] = lane_data[g];
  end

`ifdef DEMUX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule
